uart_word_rx: RTL

UART_WORD_RX -- requirements
Module: uart_word_rx

---
 rtl/uart_word_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx
//    Receives 8N1 serial frames and packs four accepted bytes, LSB lane first,
//    into a 32-bit word for a downstream word register.
//
//    clk        system clock, rising edge
//    res        asynchronous reset, active low
//    rx         asynchronous serial input, idle high
//    clr        synchronous abort of the current frame and any partial word
//    d_out      last completed word, held between strobes
//    we         one-cycle write strobe accompanying a new d_out
//    frame_err  one-cycle pulse when a stop bit samples low
//    busy       high whenever the receiver is not idle
//
//    state | meaning
//    ------+-----------------------------------------------------------
//    IDLE  | line idle, waiting for a falling edge on the synced rx
//    START | timing to the middle of the start bit to confirm it
//    DATA  | sampling the 8 data bits, one per bit period, LSB first
//    STOP  | sampling the stop bit, then accept or reject the byte

module uart_word_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        res,
   input  logic        rx,
   input  logic        clr,
   output logic [31:0] d_out,
   output logic        we,
   output logic        frame_err,
   output logic        busy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_MID  = TW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_idx;
   logic [1:0]      byte_idx;
   logic [7:0]      shreg;
   logic [31:0]     buffer;
   logic            rx_meta, rxs;
   logic [1:0]      sync_fill;
   logic            armed;

   logic            timer_clr;
   logic            bit_smp;
   logic            stop_ok;
   logic            stop_bad;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // The synchronizer resets high, so right after reset rxs does not yet
   // reflect the line. Starts are only accepted once the flushed rxs has
   // been seen high, so a release in the middle of a low bit cannot be
   // mistaken for a fresh start edge.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && rxs)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      bit_smp   = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs && armed) begin
               state_nxt = START;
               timer_clr = 1'b1;
            end
         end
         START: begin
            if (timer == T_MID) begin
               timer_clr = 1'b1;
               state_nxt = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == T_LAST) begin
               timer_clr = 1'b1;
               bit_smp   = 1'b1;
               if (bit_idx == 3'd7)
                  state_nxt = STOP;
            end
         end
         STOP: begin
            if (timer == T_LAST) begin
               timer_clr = 1'b1;
               state_nxt = IDLE;
               stop_ok   = rxs;
               stop_bad  = !rxs;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Abort overrides every same-cycle completion or error.
      if (clr) begin
         state_nxt = IDLE;
         timer_clr = 1'b1;
         bit_smp   = 1'b0;
         stop_ok   = 1'b0;
         stop_bad  = 1'b0;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge res) begin
      if (!res)
         timer <= '0;
      else if (timer_clr)
         timer <= '0;
      else if (state != IDLE)
         timer <= timer + TW'(1);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         bit_idx   <= 3'd0;
         byte_idx  <= 2'd0;
         shreg     <= 8'h00;
         buffer    <= 32'h0000_0000;
         d_out     <= 32'h0000_0000;
         we        <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         we        <= 1'b0;
         frame_err <= stop_bad;
         if (clr) begin
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            buffer   <= 32'h0000_0000;
         end else begin
            if (state == IDLE)
               bit_idx <= 3'd0;
            if (bit_smp) begin
               shreg   <= {rxs, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
            if (stop_ok) begin
               if (byte_idx == 2'd3) begin
                  // Lane 3 completes the word; it goes straight to d_out so
                  // a partial word never becomes visible.
                  d_out    <= {shreg, buffer[23:0]};
                  we       <= 1'b1;
                  buffer   <= 32'h0000_0000;
                  byte_idx <= 2'd0;
               end else begin
                  case (byte_idx)
                     2'd0:    buffer[7:0]   <= shreg;
                     2'd1:    buffer[15:8]  <= shreg;
                     default: buffer[23:16] <= shreg;
                  endcase
                  byte_idx <= byte_idx + 2'd1;
               end
            end
         end
      end
   end

endmodule
